// File: rtl/sreg_rotate_ctrl.sv
// Command sequencer that drives an N-bit load/rotate shift register through one rotate job at a time.
// Optional SREG_ROTATE_CTRL_SHORTEST_EN: rotate the short way round (min(amt, N-amt) cycles).
module sreg_rotate_ctrl #(
   parameter int N = 8
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_dir,
   input  logic [$clog2(N)-1:0]   cmd_amt,
   input  logic [N-1:0]           cmd_data,
   output logic                   rot_load,
   output logic [1:0]             rot_en,
   output logic [N-1:0]           rot_d,
   input  logic [N-1:0]           rot_q,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [N-1:0]           res_data,
   output logic                   busy
);

   localparam int AW = $clog2(N);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CAPTURE,
      RESP
   } state_t;

   state_t          state;
   logic [N-1:0]    data_q;
   logic            dir_q;
   logic [AW-1:0]   count;

   logic            acc_dir;
   logic [AW-1:0]   acc_cnt;

`ifdef SREG_ROTATE_CTRL_SHORTEST_EN
   // Rotating by amt one way equals rotating by N-amt the other way.
   always_comb begin
      acc_dir = cmd_dir;
      acc_cnt = cmd_amt;
      if (int'(cmd_amt) > N / 2) begin
         acc_dir = ~cmd_dir;
         acc_cnt = AW'(N - int'(cmd_amt));
      end
   end
`else
   assign acc_dir = cmd_dir;
   assign acc_cnt = cmd_amt;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         dir_q     <= 1'b0;
         count     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  data_q <= cmd_data;
                  dir_q  <= acc_dir;
                  count  <= acc_cnt;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               state <= (count != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
               // count holds the rotates still to issue, including this cycle's
               count <= count - AW'(1);
               if (count == AW'(1)) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               res_data  <= rot_q;
               res_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Rotator controls are pure state decodes so reset forces them quiet immediately.
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rot_load  = (state == LOAD);
   assign rot_d     = (state == LOAD) ? data_q : '0;
   assign rot_en    = (state == SHIFT) ? (dir_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
